// File: rtl/ws2812b_pkg.sv
// Shared WS2812B definitions: code timing, decode thresholds, receiver states
// and the GRB word layout. The LED driver uses the same package.
package ws2812b_pkg;

    localparam int CLKS_PER_BIT  = 62;
    localparam int T1H           = 39;
    localparam int T1L           = 23;
    localparam int T0H           = 19;
    localparam int T0L           = 43;
    localparam int BIT_THRESHOLD = 29;
    localparam int MIN_HIGH      = 8;
    localparam int MAX_HIGH      = 52;
    localparam int LATCH_CLKS    = 2600;
    localparam int MAX_POS       = 16;

    localparam int GRB_BITS = 24;
    localparam int G_LSB    = 16;
    localparam int R_LSB    = 8;
    localparam int B_LSB    = 0;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } rx_state_e;

    function automatic logic [7:0] grb_field(input logic [GRB_BITS-1:0] word, input int lsb);
        return word[lsb +: 8];
    endfunction

endpackage

// File: rtl/ws2812b_pulse_classifier.sv
// Line front end: synchronizes din, detects edges, measures high and low runs
// and turns each completed high pulse into a bit or a glitch.
module ws2812b_pulse_classifier
    import ws2812b_pkg::*;
#(
    parameter int BIT_THRESHOLD = ws2812b_pkg::BIT_THRESHOLD,
    parameter int MIN_HIGH      = ws2812b_pkg::MIN_HIGH,
    parameter int MAX_HIGH      = ws2812b_pkg::MAX_HIGH,
    parameter int LATCH_CLKS    = ws2812b_pkg::LATCH_CLKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic bit_strobe,
    output logic bit_value,
    output logic glitch,
    output logic latch
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(LATCH_CLKS + 1);
    localparam logic [HW-1:0] HI_SAT = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] HI_MIN = HW'(MIN_HIGH);
    localparam logic [HW-1:0] HI_MAX = HW'(MAX_HIGH);
    localparam logic [HW-1:0] HI_THR = HW'(BIT_THRESHOLD);
    localparam logic [LW-1:0] LO_SAT = LW'(LATCH_CLKS);
    localparam logic [LW-1:0] LO_TRIG = LW'(LATCH_CLKS - 1);

    // [0] metastability flop, [1] synchronized line, [2] previous sample
    logic [2:0]    sync_q, sync_d;
    logic [HW-1:0] hi_cnt_q, hi_cnt_d;
    logic [LW-1:0] lo_cnt_q, lo_cnt_d;
    logic          din_s, din_prev, fall, in_range;

    always_comb begin
        sync_d   = {sync_q[1:0], din};
        din_s    = sync_q[1];
        din_prev = sync_q[2];
        rise     = din_s & ~din_prev;
        fall     = ~din_s & din_prev;

        hi_cnt_d = hi_cnt_q;
        if (rise)
            hi_cnt_d = HW'(1);
        else if (din_s && hi_cnt_q != HI_SAT)
            hi_cnt_d = hi_cnt_q + HW'(1);

        // Any high sample restarts the low run, so latch means truly consecutive low.
        lo_cnt_d = lo_cnt_q;
        if (din_s)
            lo_cnt_d = '0;
        else if (lo_cnt_q != LO_SAT)
            lo_cnt_d = lo_cnt_q + LW'(1);

        in_range   = (hi_cnt_q >= HI_MIN) && (hi_cnt_q <= HI_MAX);
        bit_strobe = fall & in_range;
        glitch     = fall & ~in_range;
        bit_value  = (hi_cnt_q >= HI_THR);
        latch      = ~din_s && (lo_cnt_q == LO_TRIG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else begin
            sync_q   <= sync_d;
            hi_cnt_q <= hi_cnt_d;
            lo_cnt_q <= lo_cnt_d;
        end
    end

endmodule

// File: rtl/ws2812b_receiver.sv
// WS2812B stream decoder: frames bits from the pulse classifier into GRB
// pixels, numbers them within a frame and reports latch and protocol errors.
module ws2812b_receiver
    import ws2812b_pkg::*;
#(
    parameter int CLKS_PER_BIT  = ws2812b_pkg::CLKS_PER_BIT,
    parameter int BIT_THRESHOLD = ws2812b_pkg::BIT_THRESHOLD,
    parameter int MIN_HIGH      = ws2812b_pkg::MIN_HIGH,
    parameter int MAX_HIGH      = ws2812b_pkg::MAX_HIGH,
    parameter int LATCH_CLKS    = ws2812b_pkg::LATCH_CLKS,
    parameter int MAX_POS       = ws2812b_pkg::MAX_POS,
    localparam int IW = $clog2(MAX_POS),
    localparam int PW = IW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    output logic          pixel_valid,
    output logic [IW-1:0] pixel_index,
    output logic [7:0]    pixel_green,
    output logic [7:0]    pixel_red,
    output logic [7:0]    pixel_blue,
    output logic          frame_done,
    output logic [PW-1:0] frame_pixels,
    output logic          frame_error
);

    localparam logic [PW-1:0] PIX_MAX  = PW'(MAX_POS);
    localparam logic [4:0]    LAST_BIT = 5'(GRB_BITS - 1);

    if (!(MIN_HIGH < BIT_THRESHOLD && BIT_THRESHOLD <= MAX_HIGH &&
          MAX_HIGH < CLKS_PER_BIT && CLKS_PER_BIT < LATCH_CLKS)) begin : g_bad_cfg
        $error("ws2812b_receiver: inconsistent timing parameters");
    end

    logic rise, bit_strobe, bit_value, glitch, latch;

    ws2812b_pulse_classifier #(
        .BIT_THRESHOLD (BIT_THRESHOLD),
        .MIN_HIGH      (MIN_HIGH),
        .MAX_HIGH      (MAX_HIGH),
        .LATCH_CLKS    (LATCH_CLKS)
    ) u_classifier (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .rise       (rise),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value),
        .glitch     (glitch),
        .latch      (latch)
    );

    rx_state_e           state_q, state_d;
    logic [GRB_BITS-2:0] shift_q, shift_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]       pix_cnt_q, pix_cnt_d;
    logic                pixel_valid_q, pixel_valid_d;
    logic [IW-1:0]       pixel_index_q, pixel_index_d;
    logic [7:0]          pixel_green_q, pixel_green_d;
    logic [7:0]          pixel_red_q, pixel_red_d;
    logic [7:0]          pixel_blue_q, pixel_blue_d;
    logic                frame_done_q, frame_done_d;
    logic [PW-1:0]       frame_pixels_q, frame_pixels_d;
    logic                frame_error_q, frame_error_d;
    logic [GRB_BITS-1:0] word;

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        pix_cnt_d      = pix_cnt_q;
        pixel_valid_d  = 1'b0;
        pixel_index_d  = pixel_index_q;
        pixel_green_d  = pixel_green_q;
        pixel_red_d    = pixel_red_q;
        pixel_blue_d   = pixel_blue_q;
        frame_done_d   = 1'b0;
        frame_pixels_d = frame_pixels_q;
        frame_error_d  = 1'b0;
        word           = {shift_q, bit_value};

        case (state_q)
            ST_SYNC: begin
                if (latch)
                    state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise)
                    state_d = ST_HIGH;
            end
            ST_HIGH: begin
                if (glitch) begin
                    frame_error_d = 1'b1;
                    shift_d       = '0;
                    bit_cnt_d     = '0;
                    pix_cnt_d     = '0;
                    state_d       = ST_SYNC;
                end else if (bit_strobe) begin
                    shift_d = word[GRB_BITS-2:0];
                    state_d = ST_LOW;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        // Overflow pixels are still framed so bit alignment holds.
                        if (pix_cnt_q < PIX_MAX) begin
                            pixel_valid_d = 1'b1;
                            pixel_index_d = pix_cnt_q[IW-1:0];
                            pixel_green_d = grb_field(word, G_LSB);
                            pixel_red_d   = grb_field(word, R_LSB);
                            pixel_blue_d  = grb_field(word, B_LSB);
                            pix_cnt_d     = pix_cnt_q + PW'(1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                    end
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (latch) begin
                    frame_done_d   = 1'b1;
                    frame_pixels_d = pix_cnt_q;
                    frame_error_d  = (bit_cnt_q != '0);
                    shift_d        = '0;
                    bit_cnt_d      = '0;
                    pix_cnt_d      = '0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_SYNC;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            pix_cnt_q      <= '0;
            pixel_valid_q  <= 1'b0;
            pixel_index_q  <= '0;
            pixel_green_q  <= '0;
            pixel_red_q    <= '0;
            pixel_blue_q   <= '0;
            frame_done_q   <= 1'b0;
            frame_pixels_q <= '0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            pix_cnt_q      <= pix_cnt_d;
            pixel_valid_q  <= pixel_valid_d;
            pixel_index_q  <= pixel_index_d;
            pixel_green_q  <= pixel_green_d;
            pixel_red_q    <= pixel_red_d;
            pixel_blue_q   <= pixel_blue_d;
            frame_done_q   <= frame_done_d;
            frame_pixels_q <= frame_pixels_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign pixel_valid  = pixel_valid_q;
    assign pixel_index  = pixel_index_q;
    assign pixel_green  = pixel_green_q;
    assign pixel_red    = pixel_red_q;
    assign pixel_blue   = pixel_blue_q;
    assign frame_done   = frame_done_q;
    assign frame_pixels = frame_pixels_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Randomized WS2812B stream bench: an event-level frame model predicts the
// pixel/frame/error strobes and the observed strobe sequence is compared to it.
module tb_ws2812b_receiver;

    localparam int MIN_H   = 8;
    localparam int MAX_H   = 52;
    localparam int THR     = 29;
    localparam int LATCH   = 2600;
    localparam int NPOS    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din = 1'b0;
    logic       pixel_valid;
    logic [3:0] pixel_index;
    logic [7:0] pixel_green, pixel_red, pixel_blue;
    logic       frame_done;
    logic [4:0] frame_pixels;
    logic       frame_error;

    always #5 clk = ~clk;

    ws2812b_receiver dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .pixel_valid  (pixel_valid),
        .pixel_index  (pixel_index),
        .pixel_green  (pixel_green),
        .pixel_red    (pixel_red),
        .pixel_blue   (pixel_blue),
        .frame_done   (frame_done),
        .frame_pixels (frame_pixels),
        .frame_error  (frame_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Event encoding: [39:38] kind (1 pixel, 2 frame, 3 error), [36:32] index/count,
    // [31] frame error flag, [23:0] GRB word.
    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];

    function automatic logic [39:0] ev_pix(input int idx, input logic [23:0] w);
        return {2'd1, 1'b0, 5'(idx), 8'd0, w};
    endfunction
    function automatic logic [39:0] ev_frame(input int n, input logic err);
        return {2'd2, 1'b0, 5'(n), err, 31'd0};
    endfunction
    function automatic logic [39:0] ev_err();
        return {2'd3, 38'd0};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (pixel_valid)
                obs_q.push_back(ev_pix(int'(pixel_index), {pixel_green, pixel_red, pixel_blue}));
            if (frame_done)
                obs_q.push_back(ev_frame(int'(frame_pixels), frame_error));
            else if (frame_error)
                obs_q.push_back(ev_err());
        end
    end

    // Reference model: frame-level view of the protocol rules.
    bit          m_sync, m_active;
    int          m_bits, m_pix;
    logic [23:0] m_word;

    task automatic m_clear();
        m_active = 0; m_bits = 0; m_pix = 0; m_word = '0;
    endtask

    task automatic m_pulse(input int len);
        if (!m_sync) return;
        if (len < MIN_H || len > MAX_H) begin
            exp_q.push_back(ev_err());
            m_clear();
            m_sync = 0;
            return;
        end
        m_active = 1;
        m_word = {m_word[22:0], (len >= THR) ? 1'b1 : 1'b0};
        m_bits++;
        if (m_bits == 24) begin
            if (m_pix < NPOS) begin
                exp_q.push_back(ev_pix(m_pix, m_word));
                m_pix++;
            end
            m_bits = 0;
        end
    endtask

    task automatic m_latch();
        if (!m_sync) m_sync = 1;
        else if (m_active) exp_q.push_back(ev_frame(m_pix, m_bits != 0));
        m_clear();
    endtask

    // Stimulus
    bit nominal = 0;

    task automatic drive(input logic lvl, input int n);
        din = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pulse(input int hi, input int lo);
        drive(1'b1, hi);
        drive(1'b0, lo);
        m_pulse(hi);
    endtask

    task automatic send_bit(input logic v);
        int hi, lo, r;
        r = int'($urandom_range(0, 3));
        if (nominal) begin
            hi = v ? 39 : 19;
            lo = v ? 23 : 43;
        end else begin
            if (v) hi = (r == 0) ? THR : (r == 1) ? MAX_H : int'($urandom_range(THR, MAX_H));
            else   hi = (r == 0) ? MIN_H : (r == 1) ? THR - 1 : int'($urandom_range(MIN_H, THR - 1));
            lo = int'($urandom_range(5, 60));
        end
        send_pulse(hi, lo);
    endtask

    task automatic send_bits(input logic [23:0] w, input int first, input int last);
        for (int i = first; i >= last; i--) send_bit(w[i]);
    endtask

    task automatic send_pixel(input logic [23:0] w);
        send_bits(w, 23, 0);
    endtask

    task automatic send_latch();
        drive(1'b0, LATCH + 20);
        m_latch();
    endtask

    task automatic compare(input string tag);
        int n;
        chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk(tag, 64'(obs_q[i]), 64'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, 64'(pixel_valid), 64'd0);
        chk({tag, "_fields"}, 64'({pixel_index, pixel_green, pixel_red, pixel_blue}), 64'd0);
        chk({tag, "_frame"}, 64'({frame_done, frame_pixels, frame_error}), 64'd0);
    endtask

    initial begin
        logic [23:0] w;
        m_sync = 0;
        m_clear();

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Sync up, then one pixel with nominal code timing
        send_latch();
        nominal = 1;
        send_pixel(24'hA53CF0);
        send_latch();
        compare("one_pixel");
        nominal = 0;

        // 18 ramp pixels with jittered/boundary pulse widths: 16 emitted, count saturates
        for (int i = 0; i < 18; i++) begin
            w = {8'(i * 17), 8'(8'h40 + i), 8'(8'hFF - i)};
            send_pixel(w);
        end
        send_latch();
        compare("overflow");

        // Short glitch mid-pixel: error, ignored until a fresh latch
        send_pixel(24'($urandom));
        w = 24'($urandom);
        send_bits(w, 23, 17);
        send_pulse(4, 40);
        send_bits(w, 15, 0);
        send_latch();
        send_pixel(24'($urandom));
        send_latch();
        compare("glitch");

        // Pulse one cycle over the maximum
        send_bits(24'($urandom), 23, 21);
        send_pulse(MAX_H + 1, 30);
        send_latch();
        send_pixel(24'($urandom));
        send_latch();
        compare("long_pulse");

        // Partial pixel at latch
        send_bits(24'($urandom), 23, 14);
        send_latch();
        compare("partial");

        // Reset during bit 12 of pixel 3
        send_pixel(24'($urandom));
        send_pixel(24'($urandom));
        w = 24'($urandom);
        send_bits(w, 23, 13);
        drive(1'b1, 10);
        rst_n = 1'b0;
        m_sync = 0;
        m_clear();
        @(negedge clk);
        chk_outputs_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 10);
        drive(1'b0, 30);
        send_bits(w, 11, 0);
        send_pixel(24'($urandom));
        compare("post_reset");
        send_latch();
        send_pixel(24'($urandom));
        send_pixel(24'($urandom));
        send_latch();
        compare("resync");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
